tlul_reg_host: RTL and testbench
================================

// Module: tlul_reg_host
// PURPOSE
// - TL-UL host (initiator) adapter: converts a simple req/gnt register-access port into TL-UL A-channel
//   requests and returns D-channel responses in order. Drives any TL-UL device (rv_timer, other peripherals)
//   from a sequencer/DV master; pipelines up to MaxOutstanding transactions.
// PARAMETERS
// - MaxOutstanding  2      max A requests issued but not yet answered (1..2**SrcWidth)
// - SrcWidth        2      width of a_source actually used; upper source bits driven 0
// - TimeoutCycles   1024   cycles without a D beat before the oldest request is failed (see CONFIGURATION)
// PORTS
// - clk_i      in   1      clock
// - rst_ni     in   1      asynchronous active-low reset
// - req_i      in   1      access request, held until gnt_o
// - gnt_o      out  1      request accepted this cycle
// - addr_i     in   32     byte address; bits [1:0] ignored
// - we_i       in   1      1 = write, 0 = read
// - wdata_i    in   32     write data
// - be_i       in   4      byte enables for writes
// - valid_o    out  1      one-cycle response strobe
// - rdata_o    out  32     read data (0 for writes/errors)
// - err_o      out  1      response error, qualified by valid_o
// - tl_o       out  tl_h2d_t  TL-UL host-to-device
// - tl_i       in   tl_d2h_t  TL-UL device-to-host
// BEHAVIOUR
// - Reset: gnt_o=0 (until first cycle out of reset), valid_o=0, rdata_o=0, err_o=0, a_valid=0, outstanding=0,
//   issue/expect source counters=0; all in-flight state discarded if reset asserts mid-transaction.
// - A hold register: on req_i&gnt_o capture request, a_valid=1 next cycle; held stable until a_valid&a_ready.
// - gnt_o = (~a_valid_q | a_ready) & (outstanding_q < MaxOutstanding); outstanding counts captured, unanswered.
// - Encoding: a_opcode = we ? (be==4'hF ? PutFullData : PutPartialData) : Get; a_size=2;
//   a_mask = we ? be_i : 4'hF; a_address = {addr[31:2],2'b00}; a_data = we ? wdata : 0;
//   a_source = issue_src_q, incremented mod 2**SrcWidth per capture; a_param=0; a_user=TL_A_USER_DEFAULT.
// - d_ready tied 1. Accepted D beat (d_valid, outstanding>0, d_source==expect_src_q):
//   valid_o=1 next cycle; rdata_o = (AccessAckData & ~d_error) ? d_data : 0; err_o = d_error;
//   expect_src_q++, outstanding--. Response latency: 1 cycle after d_valid.
// - d_valid with outstanding==0 or source mismatch: dropped, no valid_o; assertion fires (except dropped
//   late beats after timeout, see CONFIGURATION).
// - Simultaneous capture and accepted D beat: outstanding unchanged; at MaxOutstanding, gnt_o stays 0 that
//   cycle (comparison uses registered count) and rises next cycle.
// - Source counters wrap 2**SrcWidth-1 -> 0; in-order D assumed, so wrap never aliases (MaxOutstanding bound).
// - valid_o is a pulse; rdata_o/err_o hold last value between pulses.
// CONFIGURATION
// - TLUL_REG_HOST_TIMEOUT_EN defined: timer counts cycles while outstanding>0 and no accepted D beat;
//   resets on any accepted beat or when outstanding==0. At TimeoutCycles: synthetic response valid_o=1,
//   err_o=1, rdata_o=0; expect_src_q++, outstanding--, timer restarts. A late D beat for the failed source
//   is silently dropped (no valid_o, no assertion). Captured-but-unissued A request is not timed out.
// - Not defined: no timer logic; host waits indefinitely for D responses.
// TESTING
// - Write 0x0000_0001 to 0x004, be=4'hF, device acks next cycle -> PutFullData, mask F; valid_o 1 cycle, err_o=0.
// - Write be=4'h3 wdata=0x1234_ABCD to 0x10A -> PutPartialData, a_address=0x108, mask=3.
// - Read 0x110, device returns AccessAckData 0xDEAD_BEEF -> rdata_o=0xDEAD_BEEF, err_o=0, 1-cycle latency.
// - 3 back-to-back reads, a_ready=1, device stalls D -> gnt_o drops after 2nd grant; rises after 1st D beat;
//   responses in order with sources 0,1,2.
// - d_error=1 on read -> valid_o=1, err_o=1, rdata_o=0; 5 reads across source wrap 3->0 complete OK.
// - TIMEOUT_EN, TimeoutCycles=16, device silent -> err_o=1 at cycle 16 after issue; late beat dropped;
//   reset asserted mid-read -> all outputs 0, next request uses source 0.

Source files
------------

// File: rtl/tlul_reg_host.sv
// TL-UL host adapter: turns a req/gnt register port into in-order TL-UL A/D traffic.
// Optional response timeout is compiled in with `define TLUL_REG_HOST_TIMEOUT_EN.

package tlul_reg_host_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  localparam logic [15:0] TL_A_USER_DEFAULT = 16'h0000;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_reg_host
  import tlul_reg_host_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SrcWidth       = 2,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic                r_init;
  logic                r_a_valid;
  tl_a_op_e            r_a_opcode;
  logic [SrcWidth-1:0] r_a_source;
  logic [31:0]         r_a_address;
  logic [3:0]          r_a_mask;
  logic [31:0]         r_a_data;
  logic [SrcWidth-1:0] r_issue_src;
  logic [SrcWidth-1:0] r_expect_src;
  logic [CntW-1:0]     r_outstanding;
  logic                r_valid;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic w_capture;
  logic w_d_acc;
  logic w_timeout;
  logic w_late_drop;
  logic w_resp;
  logic w_unused;

  // r_init keeps gnt_o low until the first clock edge after reset release
  assign gnt_o     = r_init & (~r_a_valid | tl_i.a_ready) &
                     (r_outstanding < CntW'(MaxOutstanding));
  assign w_capture = req_i & gnt_o;
  assign w_d_acc   = tl_i.d_valid & (r_outstanding != '0) &
                     (tl_i.d_source == 8'(r_expect_src));
  assign w_resp    = w_d_acc | w_timeout;
  assign w_unused  = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

`ifdef TLUL_REG_HOST_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TimeoutCycles + 1);

  logic [TmrW-1:0]     r_timer;
  logic                r_late_pend;
  logic [SrcWidth-1:0] r_late_src;
  logic                w_issued_any;

  // The hold register holds the newest request, so only older ones are on the wire
  assign w_issued_any = r_outstanding > CntW'(r_a_valid);
  assign w_timeout    = w_issued_any & ~w_d_acc & (r_timer == TmrW'(TimeoutCycles - 1));
  assign w_late_drop  = tl_i.d_valid & ~w_d_acc & r_late_pend &
                        (tl_i.d_source == 8'(r_late_src));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timer     <= '0;
      r_late_pend <= 1'b0;
      r_late_src  <= '0;
    end else begin
      if (!w_issued_any || w_d_acc || w_timeout) r_timer <= '0;
      else                                       r_timer <= r_timer + 1'b1;
      if (w_timeout) begin
        r_late_pend <= 1'b1;
        r_late_src  <= r_expect_src;
      end else if (w_late_drop) begin
        r_late_pend <= 1'b0;
      end
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign w_late_drop = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_init        <= 1'b0;
      r_a_valid     <= 1'b0;
      r_a_opcode    <= Get;
      r_a_source    <= '0;
      r_a_address   <= '0;
      r_a_mask      <= '0;
      r_a_data      <= '0;
      r_issue_src   <= '0;
      r_expect_src  <= '0;
      r_outstanding <= '0;
      r_valid       <= 1'b0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
    end else begin
      r_init <= 1'b1;
      if (w_capture) begin
        r_a_valid   <= 1'b1;
        r_a_opcode  <= we_i ? ((be_i == 4'hF) ? PutFullData : PutPartialData) : Get;
        r_a_source  <= r_issue_src;
        r_a_address <= {addr_i[31:2], 2'b00};
        r_a_mask    <= we_i ? be_i : 4'hF;
        r_a_data    <= we_i ? wdata_i : 32'h0;
        r_issue_src <= r_issue_src + 1'b1;
      end else if (tl_i.a_ready) begin
        r_a_valid <= 1'b0;
      end
      r_outstanding <= r_outstanding + CntW'(w_capture) - CntW'(w_resp);
      if (w_resp) r_expect_src <= r_expect_src + 1'b1;
      r_valid <= w_resp;
      if (w_d_acc) begin
        r_rdata <= (tl_i.d_opcode == AccessAckData && !tl_i.d_error) ? tl_i.d_data : 32'h0;
        r_err   <= tl_i.d_error;
      end else if (w_timeout) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b1;
      end
    end
  end

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = r_a_valid;
    tl_o.a_opcode  = r_a_opcode;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = 8'(r_a_source);
    tl_o.a_address = r_a_address;
    tl_o.a_mask    = r_a_mask;
    tl_o.a_data    = r_a_data;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = 1'b1;
  end

  assign valid_o = r_valid;
  assign rdata_o = r_rdata;
  assign err_o   = r_err;

  // A D beat that is neither the expected response nor a known late beat is a protocol error
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   tl_i.d_valid |-> (w_d_acc | w_late_drop));

endmodule

// File: tb/tb_tlul_reg_host.sv
// Directed bench for tlul_reg_host: encodings, latency, flow control, wrap, errors, reset.
module tb_tlul_reg_host;
  import tlul_reg_host_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        valid;
  logic [31:0] rdata;
  logic        err;
  tl_h2d_t     tlo;
  tl_d2h_t     tli;

  int total = 0;
  int bad   = 0;

  tlul_reg_host #(
    .MaxOutstanding(2),
    .SrcWidth      (2),
    .TimeoutCycles (16)
  ) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req),
    .gnt_o  (gnt),
    .addr_i (addr),
    .we_i   (we),
    .wdata_i(wdata),
    .be_i   (be),
    .valid_o(valid),
    .rdata_o(rdata),
    .err_o  (err),
    .tl_o   (tlo),
    .tl_i   (tli)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req         = 1'b0;
    tli.d_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  // Hold req until granted; returns one cycle after the capture edge
  task automatic issue_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b);
    int n;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1;
    n = 0;
    while (!gnt && n < 20) begin
      tick();
      n++;
    end
    if (!gnt) check("gnt_wait", {31'b0, gnt}, 32'd1);
    tick();
    req = 1'b0;
  endtask

  task automatic single_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] b, input logic [2:0] eop,
                               input logic [31:0] eaddr, input logic [3:0] emask,
                               input logic [31:0] edata, input int esrc, input tl_d_op_e rop,
                               input logic [31:0] rdat, input logic rerr,
                               input logic [31:0] erdata);
    issue_req(w, a, d, b);
    check("a_valid", {31'b0, tlo.a_valid}, 32'd1);
    check("a_opcode", 32'(tlo.a_opcode), {29'b0, eop});
    check("a_address", tlo.a_address, eaddr);
    check("a_mask", {28'b0, tlo.a_mask}, {28'b0, emask});
    check("a_data", tlo.a_data, edata);
    check("a_source", {24'b0, tlo.a_source}, 32'(esrc));
    check("a_size", {30'b0, tlo.a_size}, 32'd2);
    tick();
    check("a_valid_drop", {31'b0, tlo.a_valid}, 32'd0);
    tli.d_valid  = 1'b1;
    tli.d_opcode = rop;
    tli.d_source = 8'(esrc);
    tli.d_data   = rdat;
    tli.d_error  = rerr;
    #1 check("valid_not_early", {31'b0, valid}, 32'd0);
    tick();
    tli.d_valid = 1'b0;
    check("valid_pulse", {31'b0, valid}, 32'd1);
    check("err", {31'b0, err}, {31'b0, rerr});
    check("rdata", rdata, erdata);
    tick();
    check("valid_end", {31'b0, valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    tli = '0;
    tli.a_ready = 1'b1;

    #3;
    check("rst_gnt", {31'b0, gnt}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_a_valid", {31'b0, tlo.a_valid}, 32'd0);
    check("rst_d_ready", {31'b0, tlo.d_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("gnt_before_first_edge", {31'b0, gnt}, 32'd0);
    tick();
    check("gnt_after_reset", {31'b0, gnt}, 32'd1);

    single_access(1'b1, 32'h004, 32'h1, 4'hF, 3'h0, 32'h004, 4'hF, 32'h1, 0,
                  AccessAck, 32'hFFFF_FFFF, 1'b0, 32'h0);
    single_access(1'b1, 32'h10A, 32'h1234_ABCD, 4'h3, 3'h1, 32'h108, 4'h3, 32'h1234_ABCD, 1,
                  AccessAck, 32'h0, 1'b0, 32'h0);
    single_access(1'b0, 32'h110, 32'hFFFF_FFFF, 4'h5, 3'h4, 32'h110, 4'hF, 32'h0, 2,
                  AccessAckData, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    single_access(1'b0, 32'h114, 32'h0, 4'h0, 3'h4, 32'h114, 4'hF, 32'h0, 3,
                  AccessAckData, 32'hCAFE_F00D, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      single_access(1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'hF, 3'h4, 32'h200 + 32'(4 * i), 4'hF,
                    32'h0, i % 4, AccessAckData, 32'hA500_0000 + 32'(i), 1'b0,
                    32'hA500_0000 + 32'(i));
    end

    // Back-to-back reads with the device stalling D
    apply_reset();
    req = 1'b1; we = 1'b0; addr = 32'h300;
    #1 check("b2b_gnt0", {31'b0, gnt}, 32'd1);
    tick();
    addr = 32'h304;
    #1 check("b2b_gnt1", {31'b0, gnt}, 32'd1);
    check("b2b_src0", {24'b0, tlo.a_source}, 32'd0);
    tick();
    addr = 32'h308;
    #1 check("b2b_gnt_full", {31'b0, gnt}, 32'd0);
    check("b2b_src1", {24'b0, tlo.a_source}, 32'd1);
    check("b2b_addr1", tlo.a_address, 32'h304);
    tick();
    tli.d_valid = 1'b1; tli.d_opcode = AccessAckData; tli.d_error = 1'b0;
    tli.d_source = 8'd0; tli.d_data = 32'h100;
    #1 check("b2b_gnt_same_cycle", {31'b0, gnt}, 32'd0);
    check("b2b_a_idle", {31'b0, tlo.a_valid}, 32'd0);
    tick();
    tli.d_source = 8'd1; tli.d_data = 32'h101;
    #1 check("b2b_rsp0_valid", {31'b0, valid}, 32'd1);
    check("b2b_rsp0_data", rdata, 32'h100);
    check("b2b_gnt_rise", {31'b0, gnt}, 32'd1);
    tick();
    req = 1'b0; tli.d_valid = 1'b0;
    check("b2b_rsp1_valid", {31'b0, valid}, 32'd1);
    check("b2b_rsp1_data", rdata, 32'h101);
    check("b2b_src2", {24'b0, tlo.a_source}, 32'd2);
    check("b2b_addr2", tlo.a_address, 32'h308);
    tick();
    check("b2b_gap", {31'b0, valid}, 32'd0);
    tli.d_valid = 1'b1; tli.d_source = 8'd2; tli.d_data = 32'h102;
    tick();
    tli.d_valid = 1'b0;
    check("b2b_rsp2_valid", {31'b0, valid}, 32'd1);
    check("b2b_rsp2_data", rdata, 32'h102);
    tick();
    check("b2b_end", {31'b0, valid}, 32'd0);

    // Reset while a read is in flight
    issue_req(1'b0, 32'h400, 32'h0, 4'hF);
    check("mid_src3", {24'b0, tlo.a_source}, 32'd3);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, valid}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_err", {31'b0, err}, 32'd0);
    check("mid_rst_a_valid", {31'b0, tlo.a_valid}, 32'd0);
    check("mid_rst_gnt", {31'b0, gnt}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    single_access(1'b0, 32'h404, 32'h0, 4'hF, 3'h4, 32'h404, 4'hF, 32'h0, 0,
                  AccessAckData, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA);

`ifdef TLUL_REG_HOST_TIMEOUT_EN
    begin
      int n;
      issue_req(1'b0, 32'h500, 32'h0, 4'hF);
      check("to_src", {24'b0, tlo.a_source}, 32'd1);
      tick();
      n = 0;
      while (!valid && n < 40) begin
        tick();
        n++;
      end
      check("to_cycles", 32'(n), 32'd16);
      check("to_err", {31'b0, err}, 32'd1);
      check("to_rdata", rdata, 32'd0);
      tick();
      check("to_pulse_end", {31'b0, valid}, 32'd0);
      tli.d_valid = 1'b1; tli.d_source = 8'd1; tli.d_opcode = AccessAckData;
      tli.d_data = 32'h7777_7777; tli.d_error = 1'b0;
      tick();
      tli.d_valid = 1'b0;
      check("to_late_dropped", {31'b0, valid}, 32'd0);
      tick();
      check("to_late_quiet", {31'b0, valid}, 32'd0);
      single_access(1'b0, 32'h504, 32'h0, 4'hF, 3'h4, 32'h504, 4'hF, 32'h0, 2,
                    AccessAckData, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
